tx_delay_pulser: RTL and testbench

//  Per-channel transmit focusing block: the transmit counterpart of the per-channel receive delay channel.
//  On each fire it looks up the transmit delay for the requested scan line in a writable LUT.
//  It waits that many clocks, then emits a bipolar pulse burst on pulse_p/pulse_n.
//  It holds tx_en high for the whole shot; tx_en drives the receive chain's tx_en, which blanks receive.

---
 rtl/tx_delay_pulser_if.sv | 31 +++
 rtl/tx_delay_pulser.sv | 155 +++++++++++++++
 tb/tb_tx_delay_pulser.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/tx_delay_pulser_if.sv
// Control, LUT-write and pulse-output bundle of the per-channel transmit delay pulser.
// The master side drives fire/LUT writes; the slave side (the pulser) drives the pulses and status.
interface tx_delay_pulser_if #(
    parameter int DLY_WD  = 12,
    parameter int ADDR_WD = 7,
    parameter int HALF_WD = 6,
    parameter int NCYC_WD = 4
);
    logic [ADDR_WD-1:0] lut_addr;
    logic [DLY_WD-1:0]  lut_wdata;
    logic               lut_we;
    logic               fire;
    logic [ADDR_WD-1:0] line_addr;
    logic [HALF_WD-1:0] half_period;
    logic [NCYC_WD-1:0] n_cycles;
    logic               pulse_p;
    logic               pulse_n;
    logic               tx_en;
    logic               busy;
    logic               done;

    modport master (
        output lut_addr, lut_wdata, lut_we, fire, line_addr, half_period, n_cycles,
        input  pulse_p, pulse_n, tx_en, busy, done
    );

    modport slave (
        input  lut_addr, lut_wdata, lut_we, fire, line_addr, half_period, n_cycles,
        output pulse_p, pulse_n, tx_en, busy, done
    );
endinterface

// File: rtl/tx_delay_pulser.sv
// Per-channel transmit focusing: look up the scan-line delay, wait it out, then fire a
// bipolar burst of n_cycles periods (2*half_period clocks each) while holding tx_en high.
module tx_delay_pulser #(
    parameter int DLY_WD  = 12,
    parameter int ADDR_WD = 7,
    parameter int HALF_WD = 6,
    parameter int NCYC_WD = 4
) (
    input  logic               clk,
    input  logic               rst,
    tx_delay_pulser_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        DELAY  = 3'd2,
        PULSE  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [DLY_WD-1:0]  lut [2**ADDR_WD];
    logic [DLY_WD-1:0]  rd_data;
    logic [ADDR_WD-1:0] rd_addr;

    logic [ADDR_WD-1:0] line_q,   line_nxt;
    logic [HALF_WD-1:0] half_q,   half_nxt;
    logic [NCYC_WD-1:0] ncyc_q,   ncyc_nxt;
    logic [DLY_WD-1:0]  dly_cnt,  dly_nxt;
    logic [HALF_WD-1:0] half_cnt, half_cnt_nxt;
    logic               phase,    phase_nxt;
    logic [NCYC_WD-1:0] cyc_cnt,  cyc_cnt_nxt;
    logic               pulse_p_q, pulse_p_nxt;
    logic               pulse_n_q, pulse_n_nxt;

    // The read is launched on the accepting edge so the delay is ready to load at the end of LOOKUP.
    assign rd_addr = (state == IDLE) ? bus.line_addr : line_q;

    // NOTE: the delay table is deliberately left out of reset so focusing survives a shot abort;
    // the read register reads before the same-edge write, so a write never affects a read in flight.
    always_ff @(posedge clk) begin
        if (bus.lut_we) begin
            lut[bus.lut_addr] <= bus.lut_wdata;
        end
        rd_data <= lut[rd_addr];
    end

    // NOTE: every state element uses non-blocking assignment so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            line_q    <= '0;
            half_q    <= '0;
            ncyc_q    <= '0;
            dly_cnt   <= '0;
            half_cnt  <= '0;
            phase     <= 1'b0;
            cyc_cnt   <= '0;
            pulse_p_q <= 1'b0;
            pulse_n_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            line_q    <= line_nxt;
            half_q    <= half_nxt;
            ncyc_q    <= ncyc_nxt;
            dly_cnt   <= dly_nxt;
            half_cnt  <= half_cnt_nxt;
            phase     <= phase_nxt;
            cyc_cnt   <= cyc_cnt_nxt;
            pulse_p_q <= pulse_p_nxt;
            pulse_n_q <= pulse_n_nxt;
        end
    end

    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    always_comb begin
        state_nxt    = state;
        line_nxt     = line_q;
        half_nxt     = half_q;
        ncyc_nxt     = ncyc_q;
        dly_nxt      = dly_cnt;
        half_cnt_nxt = half_cnt;
        phase_nxt    = phase;
        cyc_cnt_nxt  = cyc_cnt;
        pulse_p_nxt  = 1'b0;
        pulse_n_nxt  = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.fire) begin
                    line_nxt  = bus.line_addr;
                    half_nxt  = (bus.half_period == '0) ? HALF_WD'(1) : bus.half_period;
                    ncyc_nxt  = bus.n_cycles;
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                dly_nxt   = rd_data;
                state_nxt = DELAY;
            end
            DELAY: begin
                // Count down to zero and exit on the zero cycle; no wrap even at the maximum delay.
                if (dly_cnt == '0) begin
                    if (ncyc_q != '0) begin
                        half_cnt_nxt = HALF_WD'(1);
                        phase_nxt    = 1'b0;
                        cyc_cnt_nxt  = NCYC_WD'(1);
                        pulse_p_nxt  = 1'b1;
                        state_nxt    = PULSE;
                    end else begin
                        state_nxt = DONE;
                    end
                end else begin
                    dly_nxt = dly_cnt - DLY_WD'(1);
                end
            end
            PULSE: begin
                pulse_p_nxt = pulse_p_q;
                pulse_n_nxt = pulse_n_q;
                if (half_cnt == half_q) begin
                    half_cnt_nxt = HALF_WD'(1);
                    if (!phase) begin
                        phase_nxt   = 1'b1;
                        pulse_p_nxt = 1'b0;
                        pulse_n_nxt = 1'b1;
                    end else if (cyc_cnt == ncyc_q) begin
                        pulse_p_nxt = 1'b0;
                        pulse_n_nxt = 1'b0;
                        state_nxt   = DONE;
                    end else begin
                        cyc_cnt_nxt = cyc_cnt + NCYC_WD'(1);
                        phase_nxt   = 1'b0;
                        pulse_p_nxt = 1'b1;
                        pulse_n_nxt = 1'b0;
                    end
                end else begin
                    half_cnt_nxt = half_cnt + HALF_WD'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.pulse_p = pulse_p_q;
    assign bus.pulse_n = pulse_n_q;
    assign bus.tx_en   = (state == LOOKUP) || (state == DELAY) || (state == PULSE);
    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);
endmodule

// File: tb/tb_tx_delay_pulser.sv
// Bench for tx_delay_pulser: directed table, multi-cycle corner sequences and random shots,
// all compared cycle by cycle against a shot-timing model built from plain arithmetic.
module tb_tx_delay_pulser;
    localparam int DLY_WD  = 12;
    localparam int ADDR_WD = 7;
    localparam int HALF_WD = 6;
    localparam int NCYC_WD = 4;

    logic clk;
    logic rst;

    tx_delay_pulser_if #(
        .DLY_WD(DLY_WD), .ADDR_WD(ADDR_WD), .HALF_WD(HALF_WD), .NCYC_WD(NCYC_WD)
    ) bus ();

    tx_delay_pulser #(
        .DLY_WD(DLY_WD), .ADDR_WD(ADDR_WD), .HALF_WD(HALF_WD), .NCYC_WD(NCYC_WD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int mdl_lut [2**ADDR_WD];

    typedef struct {
        int line;
        int dly;
        int h;
        int n;
        int exp_first;
        int exp_done;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input int k, input int got, input int exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at k=%0d: got %0d expected %0d", name, k, got, exp);
        end
    endtask

    // Expected {pulse_p, pulse_n, tx_en, busy, done} k cycles after the accepting edge.
    function automatic logic [4:0] exp_outputs(input int k, input int d, input int he, input int n);
        int start, len, last;
        logic p, m;
        start = 2 + d;
        len   = 2 * he * n;
        last  = start + len;
        p = 1'b0;
        m = 1'b0;
        if (k >= start && k < start + len) begin
            if (((k - start) / he) % 2 == 0) p = 1'b1;
            else m = 1'b1;
        end
        return {p, m, (k < last), (k <= last), (k == last)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_lut(input int addr, input int data);
        bus.lut_we    = 1'b1;
        bus.lut_addr  = ADDR_WD'(addr);
        bus.lut_wdata = DLY_WD'(data);
        step();
        bus.lut_we    = 1'b0;
        mdl_lut[addr] = data;
    endtask

    // One shot from an idle DUT; returns with the DUT back in IDLE, one cycle after done.
    task automatic shot(input int line, input int h, input int n, input bit hold,
                        input bit wr_lookup, input int wr_data,
                        input int exp_first, input int exp_done);
        int d, he, last, first_k, done_k;
        logic [4:0] got, exp;
        d    = mdl_lut[line];
        he   = (h == 0) ? 1 : h;
        last = 2 + d + 2 * he * n;
        bus.fire        = 1'b1;
        bus.line_addr   = ADDR_WD'(line);
        bus.half_period = HALF_WD'(h);
        bus.n_cycles    = NCYC_WD'(n);
        step();
        if (!hold) bus.fire = 1'b0;
        // Scramble the shot inputs so only the captured copies can produce the right burst.
        bus.line_addr   = ADDR_WD'($urandom);
        bus.half_period = HALF_WD'($urandom);
        bus.n_cycles    = NCYC_WD'($urandom);
        first_k = -1;
        done_k  = -1;
        for (int k = 0; k <= last + 1; k++) begin
            if (wr_lookup && k == 0) begin
                bus.lut_we    = 1'b1;
                bus.lut_addr  = ADDR_WD'(line);
                bus.lut_wdata = DLY_WD'(wr_data);
            end
            if (wr_lookup && k == 1) begin
                bus.lut_we    = 1'b0;
                mdl_lut[line] = wr_data;
            end
            got = {bus.pulse_p, bus.pulse_n, bus.tx_en, bus.busy, bus.done};
            exp = exp_outputs(k, d, he, n);
            check("outputs{p,n,tx_en,busy,done}", k, int'(got), int'(exp));
            check("p_n_overlap", k, int'(got[4] & got[3]), 0);
            if (got[4] && first_k < 0) first_k = k;
            if (got[0]) done_k = k;
            if (k <= last) step();
        end
        check("first_pulse_cycle", line, first_k, exp_first);
        check("done_cycle", line, done_k, exp_done);
    endtask

    initial begin
        int done_seen, busy_seen;
        int line, h, n, d;

        rst           = 1'b1;
        bus.lut_we    = 1'b0;
        bus.lut_addr  = '0;
        bus.lut_wdata = '0;
        bus.fire      = 1'b0;
        bus.line_addr = '0;
        bus.half_period = '0;
        bus.n_cycles  = '0;
        repeat (3) step();
        check("reset_outputs", 0,
              int'({bus.pulse_p, bus.pulse_n, bus.tx_en, bus.busy, bus.done}), 0);
        rst = 1'b0;

        for (int a = 0; a < 2**ADDR_WD; a++) wr_lut(a, int'($urandom_range(0, 30)));

        // Directed shots: {line, delay, H, N, first pulse cycle, done cycle}.
        vecs[0] = '{line: 3, dly: 5, h: 2, n: 3, exp_first: 7,  exp_done: 19};
        vecs[1] = '{line: 0, dly: 0, h: 1, n: 1, exp_first: 2,  exp_done: 4};
        vecs[2] = '{line: 0, dly: 0, h: 0, n: 1, exp_first: 2,  exp_done: 4};
        vecs[3] = '{line: 1, dly: 4, h: 2, n: 0, exp_first: -1, exp_done: 6};
        for (int i = 0; i < 4; i++) begin
            wr_lut(vecs[i].line, vecs[i].dly);
            shot(vecs[i].line, vecs[i].h, vecs[i].n, 1'b0, 1'b0, 0,
                 vecs[i].exp_first, vecs[i].exp_done);
        end

        // fire held through the whole shot: ignored while busy, retriggers on the first IDLE cycle.
        wr_lut(2, 3);
        shot(2, 1, 2, 1'b1, 1'b0, 0, 5, 9);
        shot(2, 1, 2, 1'b0, 1'b0, 0, 5, 9);

        // LUT write during LOOKUP: this shot keeps the old delay, the next one sees the new delay.
        wr_lut(3, 5);
        shot(3, 2, 3, 1'b0, 1'b1, 9, 7, 19);
        shot(3, 2, 3, 1'b0, 1'b0, 0, 11, 23);

        // Reset in the middle of the burst aborts with no done strobe; the table survives.
        wr_lut(3, 5);
        bus.fire        = 1'b1;
        bus.line_addr   = ADDR_WD'(3);
        bus.half_period = HALF_WD'(2);
        bus.n_cycles    = NCYC_WD'(3);
        step();
        bus.fire = 1'b0;
        repeat (9) step();
        check("pulse_n_before_abort", 9, int'(bus.pulse_n), 1);
        rst = 1'b1;
        step();
        check("abort_outputs", 10,
              int'({bus.pulse_p, bus.pulse_n, bus.tx_en, bus.busy, bus.done}), 0);
        rst = 1'b0;
        done_seen = 0;
        busy_seen = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus.done) done_seen++;
            if (bus.busy) busy_seen++;
        end
        check("abort_no_done", 0, done_seen, 0);
        check("abort_stays_idle", 0, busy_seen, 0);
        shot(3, 2, 3, 1'b0, 1'b0, 0, 7, 19);

        // Random shots against the timing model, with occasional table rewrites.
        for (int i = 0; i < 40; i++) begin
            line = int'($urandom_range(0, 2**ADDR_WD - 1));
            h    = int'($urandom_range(0, 4));
            n    = int'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) wr_lut(line, int'($urandom_range(0, 40)));
            d = mdl_lut[line];
            shot(line, h, n, 1'b0, 1'b0, 0,
                 (n > 0) ? 2 + d : -1,
                 2 + d + 2 * ((h == 0) ? 1 : h) * n);
        end

        // Largest representable delay must count down without wrapping.
        wr_lut(127, 2**DLY_WD - 1);
        shot(127, 1, 1, 1'b0, 1'b0, 0, 2**DLY_WD + 1, 2**DLY_WD + 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
